// File: rtl/st_dr_if.sv
// Memory write bus between the store data register (master) and memory (slave).
interface st_dr_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack
  );
endinterface

// File: rtl/st_dr.sv
// Store data register and memory write sequencer for the multi-cycle CPU.
// Optional misaligned-store trap enabled by defining ST_MISALIGN_TRAP_EN.
module st_dr #(
  parameter int PHASE_W = 5,
  parameter int PH_E    = 2,
  parameter int PH_M    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase,
  input  logic               st_en,
  input  logic [1:0]         st_size,
  input  logic [31:0]        st_addr,
  input  logic [31:0]        st_data,
  st_dr_if.master            mem,
  output logic               stall,
  output logic               wr_done,
  output logic               misalign
);

  typedef enum logic [1:0] {IDLE, LOADED, REQ} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        req_q, req_d;
  logic        done_q, done_d;

  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_mis;
  logic        flag_q;

  // Only the E and M bits of the phase vector matter here.
  logic unused_phase;
  assign unused_phase = ^phase;

  always_comb begin
    cap_wdata = st_data;
    cap_be    = 4'b1111;
    cap_mis   = 1'b0;
    unique case (st_size)
      2'b00: begin
        cap_wdata = {4{st_data[7:0]}};
        cap_be    = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        cap_wdata = {2{st_data[15:0]}};
        cap_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        cap_mis   = st_addr[0];
      end
      default: begin
        cap_wdata = st_data;
        cap_be    = 4'b1111;
        cap_mis   = (st_addr[1:0] != 2'b00);
      end
    endcase
  end

`ifdef ST_MISALIGN_TRAP_EN
  logic flag_d;
  logic mis_q, mis_d;
  assign misalign = mis_q;
`else
  logic unused_mis;
  assign unused_mis = cap_mis;
  assign flag_q     = 1'b0;
  assign misalign   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    req_d   = req_q;
    done_d  = 1'b0;
    stall   = 1'b0;
`ifdef ST_MISALIGN_TRAP_EN
    flag_d  = flag_q;
    mis_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (phase[PH_E] && st_en) begin
          addr_d  = {st_addr[31:2], 2'b00};
          wdata_d = cap_wdata;
          be_d    = cap_be;
`ifdef ST_MISALIGN_TRAP_EN
          flag_d  = cap_mis;
`endif
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (phase[PH_M]) begin
          if (flag_q) begin
            // Trapped store: no bus activity, sequencer is not held.
`ifdef ST_MISALIGN_TRAP_EN
            mis_d = 1'b1;
`endif
            be_d    = '0;
            state_d = IDLE;
          end else begin
            stall   = 1'b1;
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          be_d    = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

`ifdef ST_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      mis_q  <= mis_d;
    end
  end
`endif

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = req_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;
  assign wr_done       = done_q;

endmodule

// File: tb/tb_st_dr.sv
// Directed, table-driven bench for st_dr: lane alignment, handshake timing,
// reset abandonment, spurious inputs and the misaligned-store case.
module tb_st_dr;

  localparam logic [4:0] PH_NONE = 5'b00000;
  localparam logic [4:0] PH_EX   = 5'b00100;
  localparam logic [4:0] PH_MEM  = 5'b01000;
  localparam logic [4:0] PH_WB   = 5'b10000;

  logic        clk;
  logic        rst;
  logic [4:0]  phase;
  logic        st_en;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        stall;
  logic        wr_done;
  logic        misalign;

  int unsigned checks;
  int unsigned failures;

  st_dr_if bus ();

  st_dr #(.PHASE_W(5), .PH_E(2), .PH_M(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .phase    (phase),
    .st_en    (st_en),
    .st_size  (st_size),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .mem      (bus.master),
    .stall    (stall),
    .wr_done  (wr_done),
    .misalign (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    int unsigned dly;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full store: E capture, M request, ack after v.dly wait cycles, done pulse.
  task automatic do_store(input string tag, input vec_t v);
    phase   = PH_EX;
    st_en   = 1'b1;
    st_size = v.size;
    st_addr = v.addr;
    st_data = v.data;
    step();
    phase   = PH_MEM;
    st_en   = 1'b0;
    st_addr = '0;
    st_data = '0;
    #1;
    chk({tag, " loaded stall"}, 32'(stall), 32'd1);
    chk({tag, " loaded req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, " loaded addr"}, bus.mem_addr, v.exp_addr);
    chk({tag, " loaded wdata"}, bus.mem_wdata, v.exp_wdata);
    chk({tag, " loaded be"}, 32'(bus.mem_be), 32'(v.exp_be));
    step();
    chk({tag, " req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, " we"}, 32'(bus.mem_we), 32'd1);
    chk({tag, " req addr"}, bus.mem_addr, v.exp_addr);
    chk({tag, " req wdata"}, bus.mem_wdata, v.exp_wdata);
    chk({tag, " req be"}, 32'(bus.mem_be), 32'(v.exp_be));
    chk({tag, " req stall"}, 32'(stall), 32'd1);
    for (int unsigned i = 0; i < v.dly; i++) begin
      step();
      chk({tag, " wait req"}, 32'(bus.mem_req), 32'd1);
      chk({tag, " wait stall"}, 32'(stall), 32'd1);
      chk({tag, " wait done"}, 32'(wr_done), 32'd0);
    end
    bus.mem_ack = 1'b1;
    #1;
    chk({tag, " ack stall"}, 32'(stall), 32'd0);
    step();
    bus.mem_ack = 1'b0;
    phase       = PH_WB;
    #1;
    chk({tag, " done pulse"}, 32'(wr_done), 32'd1);
    chk({tag, " done req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, " done we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, " done be"}, 32'(bus.mem_be), 32'd0);
    chk({tag, " done stall"}, 32'(stall), 32'd0);
    chk({tag, " done misalign"}, 32'(misalign), 32'd0);
    step();
    phase = PH_NONE;
    chk({tag, " done clear"}, 32'(wr_done), 32'd0);
  endtask

  vec_t va, vb;

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    phase       = PH_NONE;
    st_en       = 1'b0;
    st_size     = 2'b00;
    st_addr     = '0;
    st_data     = '0;
    bus.mem_ack = 1'b0;

    vecs[0] = '{2'b10, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 2};
    vecs[1] = '{2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000, 1};
    vecs[2] = '{2'b01, 32'h0000_0012, 32'h0000_1234, 32'h0000_0010, 32'h1234_1234, 4'b1100, 0};
    vecs[3] = '{2'b01, 32'h0000_0010, 32'hABCD_5678, 32'h0000_0010, 32'h5678_5678, 4'b0011, 1};
    vecs[4] = '{2'b11, 32'h0000_0040, 32'h0102_0304, 32'h0000_0040, 32'h0102_0304, 4'b1111, 0};
    vecs[5] = '{2'b00, 32'h0000_0001, 32'h0000_FF3C, 32'h0000_0000, 32'h3C3C_3C3C, 4'b0010, 3};
    vecs[6] = '{2'b00, 32'h8000_0002, 32'h1234_5677, 32'h8000_0000, 32'h7777_7777, 4'b0100, 0};

    step();
    step();
    chk("reset req", 32'(bus.mem_req), 32'd0);
    chk("reset we", 32'(bus.mem_we), 32'd0);
    chk("reset be", 32'(bus.mem_be), 32'd0);
    chk("reset addr", bus.mem_addr, 32'd0);
    chk("reset wdata", bus.mem_wdata, 32'd0);
    chk("reset done", 32'(wr_done), 32'd0);
    chk("reset misalign", 32'(misalign), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    rst = 1'b1;
    step();

    for (int unsigned k = 0; k < 7; k++)
      do_store($sformatf("vec%0d", k), vecs[k]);

    // Spurious ack and M phase with nothing loaded.
    phase       = PH_MEM;
    bus.mem_ack = 1'b1;
    #1;
    chk("spur stall", 32'(stall), 32'd0);
    step();
    chk("spur req", 32'(bus.mem_req), 32'd0);
    chk("spur done", 32'(wr_done), 32'd0);
    chk("spur be", 32'(bus.mem_be), 32'd0);
    chk("spur addr", bus.mem_addr, 32'h8000_0000);
    chk("spur wdata", bus.mem_wdata, 32'h7777_7777);
    phase   = PH_EX;
    st_en   = 1'b0;
    st_addr = 32'h0000_0F00;
    step();
    chk("spur noen addr", bus.mem_addr, 32'h8000_0000);
    chk("spur noen stall", 32'(stall), 32'd0);
    bus.mem_ack = 1'b0;
    phase       = PH_NONE;
    step();

    // Second E with st_en while LOADED must not overwrite the captured store.
    phase = PH_EX; st_en = 1'b1; st_size = 2'b10;
    st_addr = 32'h0000_0500; st_data = 32'h5555_AAAA;
    step();
    st_size = 2'b00; st_addr = 32'h0000_0603; st_data = 32'h0000_0099;
    step();
    chk("hold addr", bus.mem_addr, 32'h0000_0500);
    chk("hold wdata", bus.mem_wdata, 32'h5555_AAAA);
    chk("hold be", 32'(bus.mem_be), 32'hF);
    chk("hold stall", 32'(stall), 32'd0);
    chk("hold req", 32'(bus.mem_req), 32'd0);
    phase = PH_MEM; st_en = 1'b0;
    step();
    chk("hold wr req", 32'(bus.mem_req), 32'd1);
    chk("hold wr addr", bus.mem_addr, 32'h0000_0500);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    phase       = PH_NONE;
    chk("hold wr done", 32'(wr_done), 32'd1);
    step();

    // Reset while REQ is outstanding: request drops without waiting for a clock.
    phase = PH_EX; st_en = 1'b1; st_size = 2'b10;
    st_addr = 32'h0000_0300; st_data = 32'h1122_3344;
    step();
    phase = PH_MEM; st_en = 1'b0;
    step();
    chk("rstmid req before", 32'(bus.mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid req async", 32'(bus.mem_req), 32'd0);
    chk("rstmid we", 32'(bus.mem_we), 32'd0);
    chk("rstmid be", 32'(bus.mem_be), 32'd0);
    chk("rstmid stall", 32'(stall), 32'd0);
    chk("rstmid done", 32'(wr_done), 32'd0);
    step();
    rst   = 1'b1;
    phase = PH_NONE;
    step();
    chk("rstmid after done", 32'(wr_done), 32'd0);
    chk("rstmid after req", 32'(bus.mem_req), 32'd0);
    va = '{2'b01, 32'h0000_0306, 32'h0000_BEEF, 32'h0000_0304, 32'hBEEF_BEEF, 4'b1100, 1};
    do_store("post-rst", va);

    // Word store at a non-word-aligned address.
`ifdef ST_MISALIGN_TRAP_EN
    phase = PH_EX; st_en = 1'b1; st_size = 2'b10;
    st_addr = 32'h0000_0102; st_data = 32'hCAFE_F00D;
    step();
    phase = PH_MEM; st_en = 1'b0;
    #1;
    chk("mis stall", 32'(stall), 32'd0);
    step();
    chk("mis pulse", 32'(misalign), 32'd1);
    chk("mis req", 32'(bus.mem_req), 32'd0);
    chk("mis done", 32'(wr_done), 32'd0);
    chk("mis idle stall", 32'(stall), 32'd0);
    phase = PH_NONE;
    step();
    chk("mis clear", 32'(misalign), 32'd0);
    chk("mis clear req", 32'(bus.mem_req), 32'd0);
    vb = '{2'b10, 32'h0000_0200, 32'h0BAD_CAFE, 32'h0000_0200, 32'h0BAD_CAFE, 4'b1111, 0};
    do_store("mis-next", vb);
`else
    vb = '{2'b10, 32'h0000_0102, 32'hCAFE_F00D, 32'h0000_0100, 32'hCAFE_F00D, 4'b1111, 1};
    do_store("unaligned word", vb);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
